// File: rtl/simple_rom_if.sv
// simple_rom_if: read bus between the address source and the LED pattern ROM.
interface simple_rom_if;
    logic [4:0] address;
    logic [7:0] q;

    modport master (output address, input q);
    modport slave  (input address, output q);
endinterface

// File: rtl/simple_rom.sv
// simple_rom: fixed 32 x 8 LED pattern table with a registered read port.
// One read per clock, latency 1, synchronous active-low reset to 8'h00.
module simple_rom (
    input  logic         clock,
    input  logic         reset_n,
    simple_rom_if.slave  bus
);

    // Power-up value keeps the LEDs dark until the first reset edge.
    logic [7:0] q_reg = 8'h00;
    logic [7:0] word;

    // Contents image: walking one up, walking one down, fill bar, walking zero.
    always_comb begin
        word = '0;
        case (bus.address)
            5'd0:  word = 8'h01;
            5'd1:  word = 8'h02;
            5'd2:  word = 8'h04;
            5'd3:  word = 8'h08;
            5'd4:  word = 8'h10;
            5'd5:  word = 8'h20;
            5'd6:  word = 8'h40;
            5'd7:  word = 8'h80;
            5'd8:  word = 8'h80;
            5'd9:  word = 8'h40;
            5'd10: word = 8'h20;
            5'd11: word = 8'h10;
            5'd12: word = 8'h08;
            5'd13: word = 8'h04;
            5'd14: word = 8'h02;
            5'd15: word = 8'h01;
            5'd16: word = 8'h01;
            5'd17: word = 8'h03;
            5'd18: word = 8'h07;
            5'd19: word = 8'h0F;
            5'd20: word = 8'h1F;
            5'd21: word = 8'h3F;
            5'd22: word = 8'h7F;
            5'd23: word = 8'hFF;
            5'd24: word = 8'hFE;
            5'd25: word = 8'hFD;
            5'd26: word = 8'hFB;
            5'd27: word = 8'hF7;
            5'd28: word = 8'hEF;
            5'd29: word = 8'hDF;
            5'd30: word = 8'hBF;
            5'd31: word = 8'h7F;
            default: word = '0;
        endcase
    end

    // Output register: reset wins over the read.
    always_ff @(posedge clock) begin
        if (!reset_n)
            q_reg <= '0;
        else
            q_reg <= word;
    end

    assign bus.q = q_reg;

endmodule

// File: tb/tb_simple_rom.sv
// tb_simple_rom: directed vector table, hand sequences and randomized reads
// checked against a rule-based model of the pattern table.
module tb_simple_rom;

    logic clock = 1'b0;
    logic reset_n;

    always #10 clock = ~clock;

    simple_rom_if bus ();

    simple_rom dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic       rst_n;
        logic [4:0] addr;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   fails  = 0;
    logic [7:0] sweep1 [32];

    // Word contents derived directly from the four range rules.
    function automatic logic [7:0] model(input int unsigned a);
        int v;
        if (a < 8)
            v = 1 << a;
        else if (a < 16)
            v = 128 >> (a - 8);
        else if (a < 24)
            v = (2 << (a - 16)) - 1;
        else
            v = 255 - (1 << (a - 24));
        return v[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: q=%02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic void add(input logic r, input int unsigned a, input logic [7:0] e);
        vec_t v;
        v.rst_n = r;
        v.addr  = 5'(a);
        v.exp_q = e;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [7:0] sweep_exp [32];
        logic [7:0] exp_q;
        logic [4:0] a;
        logic       r;

        sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                      8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                      8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                      8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        // Reset held 3 edges at address 5, then release.
        add(1'b0, 5, 8'h00); add(1'b0, 5, 8'h00); add(1'b0, 5, 8'h00);
        add(1'b1, 5, 8'h20);
        // Full sweep.
        for (int i = 0; i < 32; i++) add(1'b1, i, sweep_exp[i]);
        // Wrap.
        add(1'b1, 30, 8'hBF); add(1'b1, 31, 8'h7F); add(1'b1, 0, 8'h01); add(1'b1, 1, 8'h02);
        // Random access.
        add(1'b1, 23, 8'hFF); add(1'b1, 24, 8'hFE); add(1'b1, 16, 8'h01); add(1'b1, 7, 8'h80);
        // Hold address 12.
        for (int i = 0; i < 4; i++) add(1'b1, 12, 8'h08);
        // Reset mid-sweep, then release at address 20.
        add(1'b0, 18, 8'h00); add(1'b0, 18, 8'h00); add(1'b1, 20, 8'h1F);

        reset_n     = 1'b1;
        bus.address = 5'd0;
        #1;
        check("power_up", bus.q, 8'h00);

        foreach (vecs[i]) begin
            reset_n     = vecs[i].rst_n;
            bus.address = vecs[i].addr;
            step();
            check($sformatf("vec%0d", i), bus.q, vecs[i].exp_q);
        end

        // Two back-to-back sweeps with wrap; second must match the first.
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.address = 5'(i);
            step();
            sweep1[i] = bus.q;
            check($sformatf("sweepA%0d", i), bus.q, model(i));
        end
        for (int i = 0; i < 32; i++) begin
            bus.address = 5'(i);
            step();
            check($sformatf("sweepB%0d", i), bus.q, sweep1[i]);
        end

        // No combinational path from address or reset_n to q.
        bus.address = 5'd12;
        step();
        check("hold_pre", bus.q, 8'h08);
        bus.address = 5'd3;
        #5;
        check("addr_no_comb", bus.q, 8'h08);
        reset_n = 1'b0;
        #3;
        check("rst_no_comb", bus.q, 8'h08);
        step();
        check("rst_edge", bus.q, 8'h00);
        reset_n = 1'b1;
        step();
        check("rst_release", bus.q, 8'h08);

        // Randomized reads with occasional reset.
        for (int i = 0; i < 300; i++) begin
            a = 5'($urandom_range(31, 0));
            r = ($urandom_range(7, 0) != 0);
            reset_n     = r;
            bus.address = a;
            exp_q = r ? model(a) : 8'h00;
            step();
            check("random", bus.q, exp_q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
